// File: rtl/i2c_bus_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// i2c_bus_pkg : field layout of the on-chip I2C frontend bus
// Rev 1.0
// ------------------------------------------------------------------
package i2c_bus_pkg;

  localparam int I2C_RX_WIDTH = 20;
  localparam int I2C_TX_WIDTH = 2;

  localparam int RX_STOP      = 19;
  localparam int RX_CONTENT   = 18;
  localparam int RX_STROBE    = 17;
  localparam int RX_BITCNT_HI = 16;
  localparam int RX_BITCNT_LO = 9;
  localparam int RX_ADDR_HI   = 8;
  localparam int RX_ADDR_LO   = 2;
  localparam int RX_RW        = 1;
  localparam int RX_ADDRESSED = 0;

  localparam int TX_CONTENT = 1;
  localparam int TX_ACK     = 0;

  typedef struct packed {
    logic       stop;
    logic       content;
    logic       strobe;
    logic [7:0] bit_count;
    logic [6:0] address;
    logic       read_wr;
    logic       addressed;
  } rx_fields_t;

endpackage
`default_nettype wire

// File: rtl/i2c_slave_regfile_if.sv
`default_nettype none
// ------------------------------------------------------------------
// i2c_slave_regfile_if : frontend <-> slave bus bundle
// Rev 1.0
// ------------------------------------------------------------------
interface i2c_slave_regfile_if;
  import i2c_bus_pkg::*;

  logic [I2C_TX_WIDTH-1:0] i2c_interface_tx;
  logic [I2C_RX_WIDTH-1:0] i2c_interface_rx;

  modport master (output i2c_interface_rx, input i2c_interface_tx);
  modport slave  (input i2c_interface_rx, output i2c_interface_tx);
endinterface
`default_nettype wire

// File: rtl/i2c_rx_unpack.sv
`default_nettype none
// ------------------------------------------------------------------
// i2c_rx_unpack : splits the frontend rx word, packs the tx word
// Rev 1.0
// ------------------------------------------------------------------
module i2c_rx_unpack
  import i2c_bus_pkg::*;
(
  input  logic [I2C_RX_WIDTH-1:0] rx,
  input  logic                    tx_content,
  input  logic                    ack,
  output rx_fields_t              fields,
  output logic [I2C_TX_WIDTH-1:0] tx
);

  always_comb begin
    fields.stop      = rx[RX_STOP];
    fields.content   = rx[RX_CONTENT];
    fields.strobe    = rx[RX_STROBE];
    fields.bit_count = rx[RX_BITCNT_HI:RX_BITCNT_LO];
    fields.address   = rx[RX_ADDR_HI:RX_ADDR_LO];
    fields.read_wr   = rx[RX_RW];
    fields.addressed = rx[RX_ADDRESSED];
  end

  always_comb begin
    tx             = '0;
    tx[TX_CONTENT] = tx_content;
    tx[TX_ACK]     = ack;
  end

endmodule
`default_nettype wire

// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ------------------------------------------------------------------
// i2c_slave_regfile : byte register file with auto-increment pointer
// Rev 1.0
// ------------------------------------------------------------------
module i2c_slave_regfile
  import i2c_bus_pkg::*;
#(
  parameter logic [6:0] I2C_ADDRESS = 7'h00,
  parameter int         NUM_REGS    = 8,
  parameter int         PTR_BITS    = 3,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic                    clk,
  input  logic                    reset,
  i2c_slave_regfile_if.slave      bus,
  output logic [8*NUM_REGS-1:0]   regs_flat,
  output logic                    wr_strobe,
  output logic [PTR_BITS-1:0]     wr_index
);

  localparam logic [PTR_BITS:0]   NUM_LIMIT = (PTR_BITS+1)'(NUM_REGS);
  localparam logic [PTR_BITS-1:0] PTR_LAST  = PTR_BITS'(NUM_REGS - 1);
  localparam logic [PTR_BITS-1:0] PTR_ONE   = PTR_BITS'(1);

  rx_fields_t          rx;
  logic                tx_content;
  logic                ack;
  logic [7:0]          regs [NUM_REGS];
  logic [PTR_BITS-1:0] ptr;
  logic                dev_q;
  logic                first_byte;
  logic                reload;
  logic [7:0]          in_shift;
  logic [7:0]          tx_shift;

  logic                dev_addressed;
  logic                txn_start;
  logic                in_range;
  logic [PTR_BITS-1:0] ptr_next;
  logic [7:0]          cur_byte;
  logic [7:0]          new_byte;
  logic                byte_end;
  logic                wr_bit;
  logic                rd_bit;
  logic                commit;
  logic                unused_fields;

  i2c_rx_unpack u_unpack (
    .rx         (bus.i2c_interface_rx),
    .tx_content (tx_content),
    .ack        (ack),
    .fields     (rx),
    .tx         (bus.i2c_interface_tx)
  );

  assign unused_fields = ^{rx.stop, rx.bit_count[7:3]};

  assign dev_addressed = rx.addressed && (rx.address == I2C_ADDRESS);
  assign txn_start     = dev_addressed && !dev_q;
  assign in_range      = ({1'b0, ptr} < NUM_LIMIT);
  assign ptr_next      = (in_range && ptr != PTR_LAST) ? ptr + PTR_ONE : '0;
  assign cur_byte      = in_range ? regs[ptr] : 8'hFF;
  assign new_byte      = {in_shift[6:0], rx.content};
  assign byte_end      = rx.bit_count[2:0] == 3'd7;
  assign wr_bit        = dev_addressed && !rx.read_wr && rx.strobe;
  assign rd_bit        = dev_addressed && rx.read_wr && rx.strobe;
  assign commit        = wr_bit && byte_end && !first_byte && in_range && !txn_start;

  // Outputs are forced idle while reset is held, even mid-transfer.
  assign ack        = dev_addressed && !reset;
  assign tx_content = (reset || !(dev_addressed && rx.read_wr)) ? 1'b1 : tx_shift[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
    end else if (commit) begin
      regs[ptr] <= new_byte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dev_q      <= 1'b0;
      ptr        <= '0;
      first_byte <= 1'b1;
      reload     <= 1'b0;
      in_shift   <= 8'h00;
      tx_shift   <= 8'hFF;
      wr_strobe  <= 1'b0;
      wr_index   <= '0;
    end else begin
      dev_q     <= dev_addressed;
      wr_strobe <= 1'b0;
      reload    <= 1'b0;
      if (txn_start) begin
        first_byte <= 1'b1;
        in_shift   <= 8'h00;
        tx_shift   <= cur_byte;
      end else begin
        if (reload) tx_shift <= cur_byte;
        if (wr_bit) begin
          in_shift <= new_byte;
          if (byte_end) begin
            if (first_byte) begin
              ptr        <= new_byte[PTR_BITS-1:0];
              first_byte <= 1'b0;
            end else begin
              if (in_range) begin
                wr_strobe <= 1'b1;
                wr_index  <= ptr;
              end
              ptr <= ptr_next;
            end
          end
        end
        // Next byte is fetched one cycle after the pointer moves.
        if (rd_bit) begin
          tx_shift <= {tx_shift[6:0], 1'b1};
          if (byte_end) begin
            ptr    <= ptr_next;
            reload <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat[8*i +: 8] = regs[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_i2c_slave_regfile : directed bench, two parameterisations
// Rev 1.0
// ------------------------------------------------------------------
module tb_i2c_slave_regfile;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stop = 1'b0, content = 1'b0, strobe = 1'b0;
  logic       addressed = 1'b0, rw = 1'b0;
  logic [7:0] bitcnt = 8'd0;
  logic [6:0] address = 7'd0;

  always #5 clk = ~clk;

  i2c_slave_regfile_if bus0 ();
  i2c_slave_regfile_if bus1 ();

  assign bus0.i2c_interface_rx = {stop, content, strobe, bitcnt, address, rw, addressed};
  assign bus1.i2c_interface_rx = {stop, content, strobe, bitcnt, address, rw, addressed};

  logic [63:0] flat0;
  logic [47:0] flat1;
  logic        wrs0, wrs1;
  logic [2:0]  wri0, wri1;

  i2c_slave_regfile #(.I2C_ADDRESS(7'h20), .NUM_REGS(8), .PTR_BITS(3), .RESET_VALUE(8'h00)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .regs_flat(flat0), .wr_strobe(wrs0), .wr_index(wri0));

  i2c_slave_regfile #(.I2C_ADDRESS(7'h30), .NUM_REGS(6), .PTR_BITS(3), .RESET_VALUE(8'h00)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .regs_flat(flat1), .wr_strobe(wrs1), .wr_index(wri1));

  wire ack0 = bus0.i2c_interface_tx[0];
  wire tx0  = bus0.i2c_interface_tx[1];
  wire ack1 = bus1.i2c_interface_tx[0];
  wire tx1  = bus1.i2c_interface_tx[1];

  int wq0[$];
  int wq1[$];
  always @(negedge clk) begin
    if (wrs0) wq0.push_back(int'(wri0));
    if (wrs1) wq1.push_back(int'(wri1));
  end

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic begin_txn(input logic [6:0] a, input logic r);
    addressed = 1'b0;
    tick(2);
    address   = a;
    rw        = r;
    bitcnt    = 8'd0;
    addressed = 1'b1;
    tick(2);
  endtask

  task automatic finish_txn();
    addressed = 1'b0;
    stop      = 1'b1;
    tick(1);
    stop      = 1'b0;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input int sel, input logic exp_ack, input string name);
    check($sformatf("%s ack", name), (sel == 0) ? ack0 : ack1, exp_ack);
    for (int i = 7; i >= 0; i--) begin
      content = b[i];
      strobe  = 1'b1;
      tick(1);
      strobe  = 1'b0;
      bitcnt  = bitcnt + 8'd1;
      tick(2);
    end
    tick(2);
  endtask

  task automatic recv_byte(input int sel, output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b       = {b[6:0], (sel == 0) ? tx0 : tx1};
      strobe  = 1'b1;
      tick(1);
      strobe  = 1'b0;
      bitcnt  = bitcnt + 8'd1;
      tick(2);
    end
    tick(2);
  endtask

  function automatic int qat(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  typedef struct {
    logic [6:0] addr;
    logic       addressed;
    logic       rw;
    logic       exp_ack;
    logic       exp_tx;
  } vec_t;

  vec_t        vecs[7];
  logic [63:0] exp0;
  logic [7:0]  rb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{7'h20, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{7'h20, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{7'h21, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{7'h20, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{7'h20, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{7'h30, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{7'h20, 1'b0, 1'b0, 1'b0, 1'b1};
    exp0 = 64'h0;

    tick(3);
    check("reset ack", ack0, 1'b0);
    check("reset tx", tx0, 1'b1);
    check("reset regs", flat0, 64'h0);
    check("reset wr_strobe", wrs0, 1'b0);
    reset = 1'b0;
    tick(2);

    // Address match / direction table (ptr 0, reg0 = 00 after reset)
    for (int v = 0; v < 7; v++) begin
      address   = vecs[v].addr;
      addressed = vecs[v].addressed;
      rw        = vecs[v].rw;
      tick(2);
      check($sformatf("vec%0d ack", v), ack0, vecs[v].exp_ack);
      check($sformatf("vec%0d tx", v), tx0, vecs[v].exp_tx);
    end

    // Write ptr=2, A5, 3C
    wq0.delete();
    begin_txn(7'h20, 1'b0);
    send_byte(8'h02, 0, 1'b1, "w1 ptr");
    send_byte(8'hA5, 0, 1'b1, "w1 d0");
    send_byte(8'h3C, 0, 1'b1, "w1 d1");
    finish_txn();
    exp0[8*2 +: 8] = 8'hA5;
    exp0[8*3 +: 8] = 8'h3C;
    check("w1 regs", flat0, exp0);
    check("w1 strobes", wq0.size(), 2);
    check("w1 idx0", qat(wq0, 0), 2);
    check("w1 idx1", qat(wq0, 1), 3);
    check("w1 ptr", dut0.ptr, 3'd4);

    // Write ptr=7, 11, 22 wraps to reg0
    wq0.delete();
    begin_txn(7'h20, 1'b0);
    send_byte(8'h07, 0, 1'b1, "w2 ptr");
    send_byte(8'h11, 0, 1'b1, "w2 d0");
    send_byte(8'h22, 0, 1'b1, "w2 d1");
    finish_txn();
    exp0[8*7 +: 8] = 8'h11;
    exp0[8*0 +: 8] = 8'h22;
    check("w2 regs", flat0, exp0);
    check("w2 idx0", qat(wq0, 0), 7);
    check("w2 idx1", qat(wq0, 1), 0);
    check("w2 ptr", dut0.ptr, 3'd1);

    // Fill regs 1..3, set ptr=1, repeated start, read 3
    begin_txn(7'h20, 1'b0);
    send_byte(8'h01, 0, 1'b1, "r fill ptr");
    send_byte(8'h81, 0, 1'b1, "r fill 1");
    send_byte(8'h42, 0, 1'b1, "r fill 2");
    send_byte(8'hFF, 0, 1'b1, "r fill 3");
    finish_txn();
    exp0[8*1 +: 8] = 8'h81;
    exp0[8*2 +: 8] = 8'h42;
    exp0[8*3 +: 8] = 8'hFF;
    begin_txn(7'h20, 1'b0);
    send_byte(8'h01, 0, 1'b1, "r ptr");
    begin_txn(7'h20, 1'b1);
    check("r ack", ack0, 1'b1);
    recv_byte(0, rb);
    check("r byte0", rb, 8'h81);
    recv_byte(0, rb);
    check("r byte1", rb, 8'h42);
    recv_byte(0, rb);
    check("r byte2", rb, 8'hFF);
    finish_txn();
    check("r ptr", dut0.ptr, 3'd4);
    check("r regs", flat0, exp0);

    // Foreign address 0x21
    wq0.delete();
    begin_txn(7'h21, 1'b0);
    check("nack tx", tx0, 1'b1);
    send_byte(8'h00, 0, 1'b0, "nack b0");
    send_byte(8'h77, 0, 1'b0, "nack b1");
    check("nack tx end", tx0, 1'b1);
    finish_txn();
    check("nack regs", flat0, exp0);
    check("nack ptr", dut0.ptr, 3'd4);
    check("nack strobes", wq0.size(), 0);

    // NUM_REGS=6: out-of-range write dropped, reads give FF
    wq1.delete();
    begin_txn(7'h30, 1'b0);
    send_byte(8'h06, 1, 1'b1, "n6 ptr");
    send_byte(8'h55, 1, 1'b1, "n6 d0");
    finish_txn();
    check("n6 strobes", wq1.size(), 0);
    check("n6 ptr", dut1.ptr, 3'd0);
    check("n6 regs", flat1, 48'h0);
    begin_txn(7'h30, 1'b0);
    send_byte(8'h06, 1, 1'b1, "n6 rp6");
    begin_txn(7'h30, 1'b1);
    recv_byte(1, rb);
    check("n6 read6", rb, 8'hFF);
    finish_txn();
    begin_txn(7'h30, 1'b0);
    send_byte(8'h07, 1, 1'b1, "n6 rp7");
    begin_txn(7'h30, 1'b1);
    recv_byte(1, rb);
    check("n6 read7", rb, 8'hFF);
    finish_txn();

    // Reset during the 4th data bit of a write
    begin_txn(7'h20, 1'b0);
    send_byte(8'h00, 0, 1'b1, "rst ptr");
    for (int i = 0; i < 3; i++) begin
      content = 1'b1;
      strobe  = 1'b1;
      tick(1);
      strobe  = 1'b0;
      bitcnt  = bitcnt + 8'd1;
      tick(2);
    end
    content = 1'b1;
    tick(1);
    reset = 1'b1;
    #2;
    check("rst ack", ack0, 1'b0);
    check("rst tx", tx0, 1'b1);
    check("rst regs", flat0, 64'h0);
    check("rst ptr", dut0.ptr, 3'd0);
    addressed = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);
    exp0 = 64'h0;
    wq0.delete();
    begin_txn(7'h20, 1'b0);
    send_byte(8'h00, 0, 1'b1, "post ptr");
    send_byte(8'h99, 0, 1'b1, "post d0");
    finish_txn();
    exp0[7:0] = 8'h99;
    check("post regs", flat0, exp0);
    check("post idx", qat(wq0, 0), 0);
    check("post ptr", dut0.ptr, 3'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
